vic_bus_arbiter: RTL and testbench
==================================

VIC_BUS_ARBITER -- requirements
Module: vic_bus_arbiter

Interface
REQ-001 SHALL have these ports, clock and reset first (name  direction  width  meaning):
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- clk_1mhz_ph1_en  in  1  one-clk pulse, start of phase 1 (VIC slot)
- clk_1mhz_ph2_en  in  1  one-clk pulse, start of phase 2 (CPU/VIC shared slot)
- i_vic_ba  in  1  VIC bus available, active-low
- i_vic_bm  in  1  VIC bus master for phase 2, active-low
- i_vic_addr_ph1  in  16  VIC phase-1 fetch address
- i_vic_addr_ph2  in  16  VIC phase-2 fetch address
- i_cpu_req  in  1  CPU access valid this cycle
- i_cpu_we  in  1  CPU write
- i_cpu_addr  in  16  CPU address
- i_cpu_wdata  in  8  CPU write data
- i_stat_clr  in  1  clear steal counter
- o_cpu_rdy  out  1  CPU RDY, registered
- o_cpu_aec  out  1  CPU address enable, registered
- o_mem_addr  out  16  RAM address
- o_mem_we  out  1  RAM write strobe
- o_mem_wdata  out  8  RAM write data
- o_err  out  1  sticky protocol error
- o_stat_count  out  16  VIC-stolen phase-2 cycle count
REQ-002 SHALL have no parameters.

Function
REQ-003 SHALL keep a phase flag: 0 on clk_1mhz_ph1_en, 1 on clk_1mhz_ph2_en; if both pulse in one clk, phase 0 wins and o_err is set.
REQ-004 SHALL run FSM CPU / BA_WAIT / VIC, evaluated only on clk_1mhz_ph2_en.
REQ-005 CPU: i_vic_ba=0 -> BA_WAIT with 2-bit wait counter=1; else stay.
REQ-006 BA_WAIT: i_vic_ba=1 -> CPU (abort); else counter==3 -> VIC; else counter+1.
REQ-007 VIC: i_vic_ba=1 -> CPU; else stay.
REQ-008 o_cpu_rdy SHALL be 0 in BA_WAIT and VIC, 1 in CPU, updated on the same clk edge as the state.
REQ-009 o_cpu_aec SHALL be 0 only in VIC.
REQ-010 o_mem_addr (combinational): phase 0 -> i_vic_addr_ph1; phase 1 and (i_vic_bm=0 or state VIC) -> i_vic_addr_ph2; else i_cpu_addr.
REQ-011 o_mem_we = phase 1 & i_cpu_req & i_cpu_we & o_cpu_aec & i_vic_bm; CPU writes in BA_WAIT SHALL complete (up to 3 cycles); CPU reads in BA_WAIT drive the address, but RDY stays low.
REQ-012 o_mem_wdata SHALL equal i_cpu_wdata.
REQ-013 i_vic_bm=0 while state != VIC at a clk_1mhz_ph2_en SHALL set o_err; the VIC still owns phase 2.
REQ-014 o_err SHALL stay set until rst.

Reset
REQ-015 rst SHALL force: state CPU, wait counter 0, phase 0, o_cpu_rdy=1, o_cpu_aec=1, o_err=0, o_stat_count=0.
REQ-016 rst SHALL take priority over all pulses; rst asserted during BA_WAIT or VIC SHALL return to CPU on the next clk.

Configuration
REQ-017 Macro VIC_BUS_ARB_STEAL_COUNT_EN defined: 16-bit counter increments on each clk_1mhz_ph2_en with i_vic_bm=0, saturates at 16'hFFFF, and is cleared synchronously by i_stat_clr (clear beats increment); o_stat_count = counter.
REQ-018 Macro undefined: no counter register; o_stat_count tied to 16'h0000; i_stat_clr ignored.

Verification
REQ-019 Reset, then 10 cycles with i_vic_ba=1 -> o_cpu_rdy=1, o_cpu_aec=1, phase-1 o_mem_addr=i_vic_addr_ph1, phase-2 o_mem_addr=i_cpu_addr.
REQ-020 i_vic_ba falls before ph2 N -> rdy=0 after ph2 N; aec=0 after ph2 N+3 (VIC); CPU write (addr 16'h0400, data 8'h41) at ph2 N+1 -> o_mem_we=1.
REQ-021 i_vic_ba=0 for 2 ph2 pulses, then 1 -> BA_WAIT aborts to CPU, rdy=1, aec never 0.
REQ-022 i_vic_bm=0 with i_vic_ba=1 at a ph2 pulse -> o_err=1 and remains 1; o_mem_addr=i_vic_addr_ph2; o_mem_we=0.
REQ-023 With VIC_BUS_ARB_STEAL_COUNT_EN: 40 ph2 pulses with i_vic_bm=0 -> o_stat_count=40; i_stat_clr with a simultaneous steal -> 0; preload to 16'hFFFF -> stays 16'hFFFF.
REQ-024 rst asserted while in VIC -> next clk rdy=1, aec=1, o_err=0.

Source files
------------

// File: rtl/vic_bus_arbiter.sv
// VIC/CPU bus arbiter: phase tracking, BA-driven ownership FSM, RAM address/write muxing.
// Optional VIC steal counter when VIC_BUS_ARB_STEAL_COUNT_EN is defined.
module vic_bus_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_1mhz_ph1_en,
    input  logic        clk_1mhz_ph2_en,
    input  logic        i_vic_ba,
    input  logic        i_vic_bm,
    input  logic [15:0] i_vic_addr_ph1,
    input  logic [15:0] i_vic_addr_ph2,
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic [15:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_wdata,
    input  logic        i_stat_clr,
    output logic        o_cpu_rdy,
    output logic        o_cpu_aec,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_we,
    output logic [7:0]  o_mem_wdata,
    output logic        o_err,
    output logic [15:0] o_stat_count
);

    typedef enum logic [1:0] {
        ST_CPU     = 2'd0,
        ST_BA_WAIT = 2'd1,
        ST_VIC     = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] wait_cnt;
    logic       phase;

    // Ownership only changes at the start of phase 2; BA must stay low
    // for three phase-2 pulses before the VIC takes AEC away from the CPU.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_CPU;
            wait_cnt  <= 2'd0;
            phase     <= 1'b0;
            o_cpu_rdy <= 1'b1;
            o_cpu_aec <= 1'b1;
            o_err     <= 1'b0;
        end else begin
            if (clk_1mhz_ph1_en) begin
                phase <= 1'b0;
            end else if (clk_1mhz_ph2_en) begin
                phase <= 1'b1;
            end
            if (clk_1mhz_ph1_en && clk_1mhz_ph2_en) begin
                o_err <= 1'b1;
            end
            if (clk_1mhz_ph2_en) begin
                if (!i_vic_bm && state != ST_VIC) begin
                    o_err <= 1'b1;
                end
                case (state)
                    ST_CPU: begin
                        if (!i_vic_ba) begin
                            state     <= ST_BA_WAIT;
                            wait_cnt  <= 2'd1;
                            o_cpu_rdy <= 1'b0;
                        end
                    end
                    ST_BA_WAIT: begin
                        if (i_vic_ba) begin
                            state     <= ST_CPU;
                            wait_cnt  <= 2'd0;
                            o_cpu_rdy <= 1'b1;
                        end else if (wait_cnt == 2'd3) begin
                            state     <= ST_VIC;
                            o_cpu_aec <= 1'b0;
                        end else begin
                            wait_cnt <= wait_cnt + 2'd1;
                        end
                    end
                    ST_VIC: begin
                        if (i_vic_ba) begin
                            state     <= ST_CPU;
                            wait_cnt  <= 2'd0;
                            o_cpu_rdy <= 1'b1;
                            o_cpu_aec <= 1'b1;
                        end
                    end
                    default: begin
                        state     <= ST_CPU;
                        wait_cnt  <= 2'd0;
                        o_cpu_rdy <= 1'b1;
                        o_cpu_aec <= 1'b1;
                    end
                endcase
            end
        end
    end

    // A VIC that asserts BM outside its granted window still gets phase 2.
    always_comb begin
        o_mem_addr = i_cpu_addr;
        if (!phase) begin
            o_mem_addr = i_vic_addr_ph1;
        end else if (!i_vic_bm || state == ST_VIC) begin
            o_mem_addr = i_vic_addr_ph2;
        end
    end

    assign o_mem_we    = phase & i_cpu_req & i_cpu_we & o_cpu_aec & i_vic_bm;
    assign o_mem_wdata = i_cpu_wdata;

`ifdef VIC_BUS_ARB_STEAL_COUNT_EN
    logic [15:0] steal_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_stat_clr) begin
            steal_cnt <= 16'h0000;
        end else if (clk_1mhz_ph2_en && !i_vic_bm && steal_cnt != 16'hFFFF) begin
            steal_cnt <= steal_cnt + 16'h0001;
        end
    end

    assign o_stat_count = steal_cnt;
`else
    logic stat_clr_unused;
    assign stat_clr_unused = i_stat_clr;
    assign o_stat_count    = 16'h0000;
`endif

endmodule

// File: tb/tb_vic_bus_arbiter.sv
// Directed bench for vic_bus_arbiter: vector table plus hand sequences for
// error, reset-in-VIC and steal-counter corner cases.
module tb_vic_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ph1_en = 1'b0;
    logic        ph2_en = 1'b0;
    logic        vic_ba = 1'b1;
    logic        vic_bm = 1'b1;
    logic [15:0] vic_addr_ph1 = 16'h1111;
    logic [15:0] vic_addr_ph2 = 16'h2222;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = 16'h0400;
    logic [7:0]  cpu_wdata = 8'h41;
    logic        stat_clr = 1'b0;
    logic        cpu_rdy, cpu_aec, mem_we, err;
    logic [15:0] mem_addr, stat_count;
    logic [7:0]  mem_wdata;

    int checks = 0;
    int errors = 0;

    vic_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .clk_1mhz_ph1_en(ph1_en), .clk_1mhz_ph2_en(ph2_en),
        .i_vic_ba(vic_ba), .i_vic_bm(vic_bm),
        .i_vic_addr_ph1(vic_addr_ph1), .i_vic_addr_ph2(vic_addr_ph2),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we),
        .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .i_stat_clr(stat_clr),
        .o_cpu_rdy(cpu_rdy), .o_cpu_aec(cpu_aec),
        .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata),
        .o_err(err), .o_stat_count(stat_count)
    );

    // clock block
    always #5 clk = ~clk;

    typedef struct {
        logic        ph1, ph2, ba, bm, req, we;
        logic        e_rdy, e_aec, e_we, e_err;
        logic [15:0] e_addr;
    } vec_t;

    vec_t vecs[32];
    int   nvec = 0;

    function automatic vec_t mk(input logic ph1, ph2, ba, bm, req, we,
                                input logic e_rdy, e_aec, e_we, e_err,
                                input logic [15:0] e_addr);
        vec_t v;
        v.ph1 = ph1; v.ph2 = ph2; v.ba = ba; v.bm = bm; v.req = req; v.we = we;
        v.e_rdy = e_rdy; v.e_aec = e_aec; v.e_we = e_we; v.e_err = e_err;
        v.e_addr = e_addr;
        return v;
    endfunction

    task automatic add(input vec_t v);
        vecs[nvec] = v;
        nvec++;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver: one clk with the given pulses, outputs sampled 1ns after the edge
    task automatic step(input logic p1, input logic p2);
        ph1_en = p1;
        ph2_en = p2;
        @(posedge clk);
        #1;
        ph1_en = 1'b0;
        ph2_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vic_ba = 1'b1; vic_bm = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; stat_clr = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        // REQ-019: ten cycles with BA high
        for (int i = 0; i < 5; i++) begin
            add(mk(1,0,1,1,0,0, 1,1,0,0,16'h1111));
            add(mk(0,1,1,1,0,0, 1,1,0,0,16'h0400));
        end
        add(mk(0,0,1,1,1,1, 1,1,1,0,16'h0400));  // CPU write in phase 2
        add(mk(1,0,1,1,1,1, 1,1,0,0,16'h1111));  // no write in phase 1
        // REQ-020: BA falls, three-pulse wait, VIC takes over
        add(mk(0,0,0,1,0,0, 1,1,0,0,16'h1111));
        add(mk(0,1,0,1,0,0, 0,1,0,0,16'h0400));  // ph2 N
        add(mk(1,0,0,1,0,0, 0,1,0,0,16'h1111));
        add(mk(0,1,0,1,1,1, 0,1,1,0,16'h0400));  // ph2 N+1, write completes
        add(mk(1,0,0,1,0,0, 0,1,0,0,16'h1111));
        add(mk(0,1,0,1,1,0, 0,1,0,0,16'h0400));  // ph2 N+2, read: addr only
        add(mk(0,1,0,1,1,1, 0,0,0,0,16'h2222));  // ph2 N+3 -> VIC
        add(mk(0,1,0,0,0,0, 0,0,0,0,16'h2222));  // BM low in VIC is legal
        add(mk(1,0,0,1,0,0, 0,0,0,0,16'h1111));
        add(mk(0,1,1,1,0,0, 1,1,0,0,16'h0400));  // BA high -> CPU
        // REQ-021: abort from BA_WAIT
        add(mk(0,1,0,1,0,0, 0,1,0,0,16'h0400));
        add(mk(0,1,0,1,0,0, 0,1,0,0,16'h0400));
        add(mk(0,1,1,1,0,0, 1,1,0,0,16'h0400));
        add(mk(0,1,1,1,0,0, 1,1,0,0,16'h0400));
        // REQ-022: BM low outside VIC ownership
        add(mk(0,1,1,0,1,1, 1,1,0,1,16'h2222));
        add(mk(0,0,1,1,0,0, 1,1,0,1,16'h0400));
        add(mk(1,0,1,1,0,0, 1,1,0,1,16'h1111));

        do_reset();
        chk("rst_rdy", {15'd0, cpu_rdy}, 16'd1);
        chk("rst_aec", {15'd0, cpu_aec}, 16'd1);
        chk("rst_err", {15'd0, err}, 16'd0);
        chk("rst_addr", mem_addr, 16'h1111);
        chk("rst_we", {15'd0, mem_we}, 16'd0);
        chk("rst_stat", stat_count, 16'h0000);

        for (int i = 0; i < nvec; i++) begin
            vic_ba = vecs[i].ba; vic_bm = vecs[i].bm;
            cpu_req = vecs[i].req; cpu_we = vecs[i].we;
            step(vecs[i].ph1, vecs[i].ph2);
            chk($sformatf("v%0d_rdy", i), {15'd0, cpu_rdy}, {15'd0, vecs[i].e_rdy});
            chk($sformatf("v%0d_aec", i), {15'd0, cpu_aec}, {15'd0, vecs[i].e_aec});
            chk($sformatf("v%0d_we", i), {15'd0, mem_we}, {15'd0, vecs[i].e_we});
            chk($sformatf("v%0d_err", i), {15'd0, err}, {15'd0, vecs[i].e_err});
            chk($sformatf("v%0d_addr", i), mem_addr, vecs[i].e_addr);
        end
        chk("wdata", {8'd0, mem_wdata}, 16'h0041);

        // both phase pulses in one clk: phase 0 wins, error set
        do_reset();
        step(1'b1, 1'b1);
        chk("both_err", {15'd0, err}, 16'd1);
        chk("both_addr", mem_addr, 16'h1111);

        // reset while in VIC (err already set by the double pulse)
        vic_ba = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
        chk("vic_aec", {15'd0, cpu_aec}, 16'd0);
        chk("vic_rdy", {15'd0, cpu_rdy}, 16'd0);
        chk("vic_err", {15'd0, err}, 16'd1);
        rst = 1'b1;
        step(1'b0, 1'b1);
        chk("rstvic_rdy", {15'd0, cpu_rdy}, 16'd1);
        chk("rstvic_aec", {15'd0, cpu_aec}, 16'd1);
        chk("rstvic_err", {15'd0, err}, 16'd0);
        step(1'b0, 1'b1);
        chk("rstprio_rdy", {15'd0, cpu_rdy}, 16'd1);
        rst = 1'b0;
        vic_ba = 1'b1;

        // steal counter
        do_reset();
        vic_bm = 1'b0;
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1);
`ifdef VIC_BUS_ARB_STEAL_COUNT_EN
        chk("steal_40", stat_count, 16'd40);
        stat_clr = 1'b1;
        step(1'b0, 1'b1);
        stat_clr = 1'b0;
        chk("steal_clr", stat_count, 16'd0);
        for (int i = 0; i < 65535; i++) step(1'b0, 1'b1);
        chk("steal_full", stat_count, 16'hFFFF);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        chk("steal_sat", stat_count, 16'hFFFF);
`else
        chk("steal_off", stat_count, 16'h0000);
        stat_clr = 1'b1;
        step(1'b0, 1'b1);
        stat_clr = 1'b0;
        chk("steal_off_clr", stat_count, 16'h0000);
`endif
        vic_bm = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
